jpeg_stream_framer: RTL

- Sequences the byte stream of one JPEG frame onto a single output bus.
- Order per frame: fixed header bytes read from the header memory, then the compressor's entropy-coded bytes, then the EOI marker FF D9.
- Sits between jfpjc's byte output and the downstream sink (SPI/UART/FIFO), replacing testbench-side header/EOI assembly.
- Acts as the arbiter granting the output bus to header memory, compressor, or EOI generator.

---
 rtl/jpeg_stream_framer.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/jpeg_stream_framer.sv
// Sequences one JPEG frame onto a single byte bus: header memory bytes, compressor body, then FF D9.
// Optional macro JFPJC_FRAMER_STUFF_EN inserts a 0x00 after every 0xFF body byte.
module jpeg_stream_framer #(
    parameter int HEADER_LEN = 328,
    parameter int ADDR_W     = 9
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] hdr_addr,
    output logic              hdr_rd,
    input  logic [7:0]        hdr_data,
    input  logic              src_valid,
    input  logic [7:0]        src_data,
    input  logic              src_last,
    output logic              src_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_dropped,
    output logic [15:0]       frame_count
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_BODY   = 3'd2,
        ST_EOI_FF = 3'd3,
        ST_EOI_D9 = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HEADER_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
    logic              rd_done_q, rd_done_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              hold_valid_q, hold_valid_d;
    logic [7:0]        hold_data_q, hold_data_d;
    logic              hold_last_q, hold_last_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              d9_loaded_q, d9_loaded_d;
    logic              frame_dropped_q, frame_dropped_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              out_free_s;
    logic              hdr_rd_s;
    logic              src_ready_s;
    logic              last_loaded_s;
`ifdef JFPJC_FRAMER_STUFF_EN
    logic              stuff_pending_q, stuff_pending_d;
    logic              stuff_last_q, stuff_last_d;
`endif

    // State and datapath registers, cleared asynchronously by nreset.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q         <= ST_IDLE;
            hdr_addr_q      <= {ADDR_W{1'b0}};
            rd_done_q       <= 1'b0;
            rd_inflight_q   <= 1'b0;
            inflight_last_q <= 1'b0;
            hold_valid_q    <= 1'b0;
            hold_data_q     <= 8'h00;
            hold_last_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= 8'h00;
            d9_loaded_q     <= 1'b0;
            frame_dropped_q <= 1'b0;
            frame_count_q   <= 16'h0000;
`ifdef JFPJC_FRAMER_STUFF_EN
            stuff_pending_q <= 1'b0;
            stuff_last_q    <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            hdr_addr_q      <= hdr_addr_d;
            rd_done_q       <= rd_done_d;
            rd_inflight_q   <= rd_inflight_d;
            inflight_last_q <= inflight_last_d;
            hold_valid_q    <= hold_valid_d;
            hold_data_q     <= hold_data_d;
            hold_last_q     <= hold_last_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            d9_loaded_q     <= d9_loaded_d;
            frame_dropped_q <= frame_dropped_d;
            frame_count_q   <= frame_count_d;
`ifdef JFPJC_FRAMER_STUFF_EN
            stuff_pending_q <= stuff_pending_d;
            stuff_last_q    <= stuff_last_d;
`endif
        end
    end

    // Next-state, bus arbitration and output-register load selection.
    always_comb begin
        state_d         = state_q;
        hdr_addr_d      = hdr_addr_q;
        rd_done_d       = rd_done_q;
        rd_inflight_d   = 1'b0;
        inflight_last_d = 1'b0;
        hold_valid_d    = hold_valid_q;
        hold_data_d     = hold_data_q;
        hold_last_d     = hold_last_q;
        out_valid_d     = out_valid_q & ~out_ready;
        out_data_d      = out_data_q;
        d9_loaded_d     = d9_loaded_q;
        frame_count_d   = frame_count_q;
        hdr_rd_s        = 1'b0;
        src_ready_s     = 1'b0;
        last_loaded_s   = 1'b0;
        out_free_s      = ~out_valid_q | out_ready;
`ifdef JFPJC_FRAMER_STUFF_EN
        stuff_pending_d = stuff_pending_q;
        stuff_last_d    = stuff_last_q;
`endif

        if (frame_start && (state_q != ST_IDLE)) begin
            frame_dropped_d = 1'b1;
        end else begin
            frame_dropped_d = frame_dropped_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d      = ST_HEADER;
                    hdr_addr_d   = {ADDR_W{1'b0}};
                    rd_done_d    = 1'b0;
                    hold_valid_d = 1'b0;
                    d9_loaded_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_HEADER: begin
                // hold buffer absorbs a read that lands while the sink is stalling
                if (out_free_s) begin
                    if (hold_valid_q) begin
                        out_valid_d   = 1'b1;
                        out_data_d    = hold_data_q;
                        last_loaded_s = hold_last_q;
                        hold_valid_d  = rd_inflight_q;
                        hold_data_d   = hdr_data;
                        hold_last_d   = inflight_last_q;
                    end else if (rd_inflight_q) begin
                        out_valid_d   = 1'b1;
                        out_data_d    = hdr_data;
                        last_loaded_s = inflight_last_q;
                    end else begin
                        last_loaded_s = 1'b0;
                    end
                end else if (rd_inflight_q) begin
                    hold_valid_d = 1'b1;
                    hold_data_d  = hdr_data;
                    hold_last_d  = inflight_last_q;
                end else begin
                    hold_valid_d = hold_valid_q;
                end

                // a new read is only issued when its data is guaranteed a slot
                if (!rd_done_q && !hold_valid_d) begin
                    hdr_rd_s        = 1'b1;
                    rd_inflight_d   = 1'b1;
                    inflight_last_d = (hdr_addr_q == LAST_ADDR);
                    if (hdr_addr_q == LAST_ADDR) begin
                        rd_done_d  = 1'b1;
                        hdr_addr_d = {ADDR_W{1'b0}};
                    end else begin
                        hdr_addr_d = hdr_addr_q + ADDR_ONE;
                    end
                end else begin
                    rd_inflight_d = 1'b0;
                end

                if (last_loaded_s) begin
                    state_d = ST_BODY;
                end else begin
                    state_d = ST_HEADER;
                end
            end

            ST_BODY: begin
`ifdef JFPJC_FRAMER_STUFF_EN
                if (stuff_pending_q) begin
                    if (out_free_s) begin
                        out_valid_d     = 1'b1;
                        out_data_d      = 8'h00;
                        stuff_pending_d = 1'b0;
                        if (stuff_last_q) begin
                            state_d = ST_EOI_FF;
                        end else begin
                            state_d = ST_BODY;
                        end
                    end else begin
                        stuff_pending_d = 1'b1;
                    end
                end else begin
                    src_ready_s = out_free_s;
                    if (src_valid && out_free_s) begin
                        out_valid_d = 1'b1;
                        out_data_d  = src_data;
                        if (src_data == 8'hFF) begin
                            stuff_pending_d = 1'b1;
                            stuff_last_d    = src_last;
                        end else if (src_last) begin
                            state_d = ST_EOI_FF;
                        end else begin
                            state_d = ST_BODY;
                        end
                    end else begin
                        state_d = ST_BODY;
                    end
                end
`else
                src_ready_s = out_free_s;
                if (src_valid && out_free_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = src_data;
                    if (src_last) begin
                        state_d = ST_EOI_FF;
                    end else begin
                        state_d = ST_BODY;
                    end
                end else begin
                    state_d = ST_BODY;
                end
`endif
            end

            ST_EOI_FF: begin
                if (out_free_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = 8'hFF;
                    state_d     = ST_EOI_D9;
                end else begin
                    state_d = ST_EOI_FF;
                end
            end

            ST_EOI_D9: begin
                if (!d9_loaded_q) begin
                    if (out_free_s) begin
                        out_valid_d = 1'b1;
                        out_data_d  = 8'hD9;
                        d9_loaded_d = 1'b1;
                    end else begin
                        d9_loaded_d = 1'b0;
                    end
                end else if (out_ready) begin
                    state_d       = ST_IDLE;
                    d9_loaded_d   = 1'b0;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    state_d = ST_EOI_D9;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign hdr_addr      = hdr_addr_q;
    assign hdr_rd        = hdr_rd_s;
    assign src_ready     = src_ready_s;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_dropped = frame_dropped_q;
    assign frame_count   = frame_count_q;

endmodule
